// File: rtl/rtc_bus_sequencer.sv
// ---------------------------------------------------------------------------
// rtc_bus_sequencer
//
// Purpose: bus-cycle engine between the PicoBlaze port decode and an external
// real-time-clock chip. A one-cycle request becomes a timed, multiplexed
// address/data cycle on the RTC pins. Read data comes back with a done pulse.
// The RTC interrupt line is synchronised into a sticky pending flag.
//
// Parameters (all >= 1):
//   T_SETUP  - cycles of each phase's setup (cs_n low, strobe inactive)
//   T_STROBE - cycles rd_n/wr_n held low
//   T_HOLD   - cycles after strobe release with cs_n still low
//   T_GAP    - cycles cs_n high between address and data phases
//
// Ports:
//   clk, reset (async, active-low)
//   start, rw, addr, wdata   - transaction request (rw: 1 = write)
//   busy, done, rdata        - status / read result
//   bus_out, bus_oe, bus_in  - RTC data bus (tristate resolved at top level)
//   cs_n, ad, rd_n, wr_n     - RTC strobes (ad: 0 = address, 1 = data)
//   irq_n, irq_ack           - raw RTC interrupt, clear request
//   irq_pending              - sticky interrupt flag
// ---------------------------------------------------------------------------
module rtc_bus_sequencer #(
    parameter int T_SETUP  = 2,
    parameter int T_STROBE = 8,
    parameter int T_HOLD   = 2,
    parameter int T_GAP    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    input  logic [7:0] bus_in,
    output logic       cs_n,
    output logic       ad,
    output logic       rd_n,
    output logic       wr_n,
    input  logic       irq_n,
    input  logic       irq_ack,
    output logic       irq_pending
);

    typedef enum logic [3:0] {
        IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rw_q, rw_d;
    logic [7:0]  addr_q, addr_d, wdata_q, wdata_d;

    logic        busy_q, busy_d, done_q, done_d;
    logic        cs_n_q, cs_n_d, ad_q, ad_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
    logic        bus_oe_q, bus_oe_d;
    logic [7:0]  bus_out_q, bus_out_d, rdata_q, rdata_d;

    logic        sync1_q, sync2_q, sync3_q;
    logic        pend_q, pend_d;

    logic        load, last, a_ph, d_ph, irq_fall;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last    = (cnt_q == 16'd1);
        load    = (state_q == IDLE) && start;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = A_SETUP;
                    cnt_d   = 16'(T_SETUP);
                end
            end
            A_SETUP: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = A_STROBE;
                    cnt_d   = 16'(T_STROBE);
                end
            end
            A_STROBE: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = A_HOLD;
                    cnt_d   = 16'(T_HOLD);
                end
            end
            A_HOLD: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = GAP;
                    cnt_d   = 16'(T_GAP);
                end
            end
            GAP: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = D_SETUP;
                    cnt_d   = 16'(T_SETUP);
                end
            end
            D_SETUP: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = D_STROBE;
                    cnt_d   = 16'(T_STROBE);
                end
            end
            D_STROBE: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = D_HOLD;
                    cnt_d   = 16'(T_HOLD);
                end
            end
            D_HOLD: begin
                cnt_d = cnt_q - 16'd1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rw_d    = load ? rw    : rw_q;
        addr_d  = load ? addr  : addr_q;
        wdata_d = load ? wdata : wdata_q;

        // Pins are decoded from the *next* state so the registered outputs
        // show the current state's values without a combinational path.
        a_ph = (state_d == A_SETUP) || (state_d == A_STROBE) || (state_d == A_HOLD);
        d_ph = (state_d == D_SETUP) || (state_d == D_STROBE) || (state_d == D_HOLD);

        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        cs_n_d    = !(a_ph || d_ph);
        ad_d      = d_ph;
        wr_n_d    = !((state_d == A_STROBE) || ((state_d == D_STROBE) && rw_d));
        rd_n_d    = !((state_d == D_STROBE) && !rw_d);
        bus_oe_d  = a_ph || (d_ph && rw_d);
        bus_out_d = a_ph ? addr_d : (d_ph ? wdata_d : 8'h00);

        // Capture on the edge that ends the read strobe.
        rdata_d = rdata_q;
        if ((state_q == D_STROBE) && (state_d != D_STROBE) && !rw_q) begin
            rdata_d = bus_in;
        end

        // Set wins over a simultaneous acknowledge.
        irq_fall = sync3_q && !sync2_q;
        pend_d   = irq_fall || (pend_q && !irq_ack);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            rw_q      <= 1'b0;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            ad_q      <= 1'b0;
            rd_n_q    <= 1'b1;
            wr_n_q    <= 1'b1;
            bus_oe_q  <= 1'b0;
            bus_out_q <= 8'h00;
            rdata_q   <= 8'h00;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            sync3_q   <= 1'b1;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            ad_q      <= ad_d;
            rd_n_q    <= rd_n_d;
            wr_n_q    <= wr_n_d;
            bus_oe_q  <= bus_oe_d;
            bus_out_q <= bus_out_d;
            rdata_q   <= rdata_d;
            sync1_q   <= irq_n;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
            pend_q    <= pend_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign cs_n        = cs_n_q;
    assign ad          = ad_q;
    assign rd_n        = rd_n_q;
    assign wr_n        = wr_n_q;
    assign bus_oe      = bus_oe_q;
    assign bus_out     = bus_out_q;
    assign rdata       = rdata_q;
    assign irq_pending = pend_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
module tb_rtc_bus_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, start1, rw, irq_n, irq_ack;
    logic [7:0] addr, wdata, bus_in;

    logic       busy0, done0, cs_n0, ad0, rd_n0, wr_n0, oe0, pend0;
    logic [7:0] bo0, rdata0;
    logic       busy1, done1, cs_n1, ad1, rd_n1, wr_n1, oe1, pend1;
    logic [7:0] bo1, rdata1;
    logic [14:0] o0, o1;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] rd_model;

    always #5 clk = ~clk;

    rtc_bus_sequencer dut0 (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy0), .done(done0), .rdata(rdata0), .bus_out(bo0), .bus_oe(oe0),
        .bus_in(bus_in), .cs_n(cs_n0), .ad(ad0), .rd_n(rd_n0), .wr_n(wr_n0),
        .irq_n(irq_n), .irq_ack(irq_ack), .irq_pending(pend0)
    );

    rtc_bus_sequencer #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_GAP(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .busy(busy1), .done(done1), .rdata(rdata1), .bus_out(bo1), .bus_oe(oe1),
        .bus_in(bus_in), .cs_n(cs_n1), .ad(ad1), .rd_n(rd_n1), .wr_n(wr_n1),
        .irq_n(irq_n), .irq_ack(irq_ack), .irq_pending(pend1)
    );

    // {busy, done, cs_n, ad, rd_n, wr_n, bus_oe, bus_out}
    assign o0 = {busy0, done0, cs_n0, ad0, rd_n0, wr_n0, oe0, bo0};
    assign o1 = {busy1, done1, cs_n1, ad1, rd_n1, wr_n1, oe1, bo1};

    localparam logic [14:0] RST_OUT = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00};

    typedef struct {
        bit         rw;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] bin;
        bit         junk;
    } txn_t;

    txn_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Expected pin waveform t cycles after the start-sampling edge.
    function automatic logic [14:0] exp_out(input int S, input int P, input int H, input int G,
                                            input int t, input bit wr,
                                            input logic [7:0] a, input logic [7:0] w);
        int L, TOT, u;
        logic b, d, c, adv, r, wn, oe;
        logic [7:0] bo;
        L = S + P + H;
        TOT = 2 * L + G;
        b = (t <= TOT); d = 1'b0; c = 1'b1; adv = 1'b0; r = 1'b1; wn = 1'b1; oe = 1'b0; bo = 8'h00;
        if (t < L) begin
            c = 1'b0; oe = 1'b1; bo = a;
            if (t >= S && t < S + P) wn = 1'b0;
        end else if (t < L + G) begin
            c = 1'b1;
        end else if (t < TOT) begin
            u = t - L - G;
            c = 1'b0; adv = 1'b1; bo = w; oe = wr;
            if (u >= S && u < S + P) begin
                if (wr) wn = 1'b0;
                else    r  = 1'b0;
            end
        end else if (t == TOT) begin
            d = 1'b1;
        end
        return {b, d, c, adv, r, wn, oe, bo};
    endfunction

    // Called at a negedge; returns at the negedge of the first idle cycle after DONE.
    task automatic run_txn(input int id, input bit wr, input logic [7:0] a, input logic [7:0] w,
                           input logic [7:0] bin, input bit junk);
        int dones;
        int t;
        logic [14:0] e;
        dones = 0;
        start = 1'b1; rw = wr; addr = a; wdata = w;
        @(posedge clk);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            t = k - 1;
            start = junk && (k == 5 || k == 28 || k == 29);
            if (start) begin
                rw = ~wr; addr = 8'hEE; wdata = 8'h11;
            end
            e = exp_out(2, 8, 2, 4, t, wr, a, w);
            chk($sformatf("txn%0d pins t%0d", id, t), 32'(o0), 32'(e));
            if (done0) dones++;
            if (!wr && t >= 18 && t < 26) bus_in = bin;
            else                          bus_in = 8'hA5;
            if (t == 28) begin
                if (!wr) rd_model = bin;
                chk($sformatf("txn%0d rdata at done", id), 32'(rdata0), 32'(rd_model));
            end
        end
        start = 1'b0;
        chk($sformatf("txn%0d done count", id), 32'(dones), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b1, 8'h21, 8'h45, 8'h00, 1'b0};
        tbl[1] = '{1'b0, 8'h23, 8'h00, 8'h59, 1'b0};
        tbl[2] = '{1'b1, 8'h3C, 8'h96, 8'h00, 1'b1};
        tbl[3] = '{1'b0, 8'h7F, 8'hAA, 8'hC3, 1'b0};
        tbl[4] = '{1'b1, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[5] = '{1'b0, 8'hFF, 8'h5A, 8'h3E, 1'b0};

        reset = 1'b0; start = 1'b0; start1 = 1'b0; rw = 1'b0; addr = 8'h00; wdata = 8'h00;
        bus_in = 8'hA5; irq_n = 1'b1; irq_ack = 1'b0; rd_model = 8'h00;

        repeat (2) @(negedge clk);
        chk("reset pins", 32'(o0), 32'(RST_OUT));
        chk("reset rdata", 32'(rdata0), 32'h0);
        chk("reset irq_pending", 32'(pend0), 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle after reset", 32'(o0), 32'(RST_OUT));

        // Back-to-back transactions from the table.
        for (int i = 0; i < 6; i++) begin
            run_txn(i, tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].bin, tbl[i].junk);
            chk($sformatf("txn%0d rdata after", i), 32'(rdata0), 32'(rd_model));
        end

        // Asynchronous reset in the data strobe of a write.
        start = 1'b1; rw = 1'b1; addr = 8'h66; wdata = 8'h99;
        @(posedge clk);
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre-reset in D_STROBE", 32'(o0), 32'({1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h99}));
        reset = 1'b0;
        #1;
        chk("async reset pins", 32'(o0), 32'(RST_OUT));
        chk("async reset rdata", 32'(rdata0), 32'h0);
        rd_model = 8'h00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("idle after mid reset", 32'(o0), 32'(RST_OUT));
        run_txn(10, 1'b0, 8'h42, 8'h00, 8'h9D, 1'b0);
        chk("read after reset rdata", 32'(rdata0), 32'h9D);

        // Minimum timing: all phases one cycle.
        start1 = 1'b1; rw = 1'b1; addr = 8'h5A; wdata = 8'hC3;
        @(posedge clk);
        for (int t = 0; t <= 8; t++) begin
            @(negedge clk);
            start1 = 1'b0;
            chk($sformatf("min-timing pins t%0d", t), 32'(o1),
                32'(exp_out(1, 1, 1, 1, t, 1'b1, 8'h5A, 8'hC3)));
        end

        // Interrupt path.
        @(negedge clk);
        irq_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("irq after 2 edges", 32'(pend0), 32'h0);
        @(negedge clk);
        chk("irq after 3 edges", 32'(pend0), 32'h1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq acked", 32'(pend0), 32'h0);
        repeat (4) @(negedge clk);
        chk("irq held low no re-set", 32'(pend0), 32'h0);
        irq_n = 1'b1;
        repeat (4) @(negedge clk);
        irq_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq set wins over ack", 32'(pend0), 32'h1);
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
        chk("irq second ack", 32'(pend0), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
